// File: rtl/sobel_fetch_ctrl_if.sv
// Memory read-port handshake between the Sobel fetch controller and pixel memory.
// The controller holds mem_req/mem_addr until mem_ack; data returns on mem_valid.
interface sobel_fetch_ctrl_if #(
   parameter int ADDRW = 21
);
   logic             mem_req;
   logic [ADDRW-1:0] mem_addr;
   logic             mem_ack;
   logic             mem_valid;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_valid);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_valid);
endinterface

// File: rtl/sobel_fetch_ctrl.sv
// Sobel row-buffer fetch sequencer: walks the image column by column, issuing
// BEATS vertically adjacent single-word reads per window, strobing pop_en per
// returned word, pulsing win_valid per window, then pausing before the next one.
module sobel_fetch_ctrl #(
   parameter int BASEADDR = 0,
   parameter int ADDRW    = 21,
   parameter int ROWWORDS = 256,
   parameter int ROWS     = 8192,
   parameter int BEATS    = 3,
   parameter int PAUSE    = 1
) (
   input  logic               nclk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   sobel_fetch_ctrl_if.master mem,
   output logic               pop_en,
   output logic               win_valid,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(ROWWORDS);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW = (PAUSE > 0) ? $clog2(PAUSE + 1) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(ROWWORDS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - BEATS);
   localparam logic [KW-1:0] K_LAST   = KW'(BEATS - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(PAUSE);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PAUSE, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [KW-1:0]    k_q, k_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             mem_req_q, mem_req_d;
   logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
   logic             win_valid_q, win_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             beat;

   // Word address of (row+k, col); everything wraps mod 2^ADDRW.
   function automatic logic [ADDRW-1:0] addr_of(input logic [RW-1:0] r,
                                                input logic [KW-1:0] kk,
                                                input logic [CW-1:0] c);
      logic [ADDRW-1:0] line;
      line = ADDRW'(r) + ADDRW'(kk);
      return ADDRW'(BASEADDR) + (line << CW) + ADDRW'(c);
   endfunction

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      k_d         = k_q;
      pcnt_d      = pcnt_q;
      win_valid_d = 1'b0;
      // A beat completes on data return: same-cycle ack+valid in REQ, or valid in WAIT.
      beat   = ((state_q == S_REQ) && mem.mem_ack && mem.mem_valid) ||
               ((state_q == S_WAIT) && mem.mem_valid);
      pop_en = beat;

      case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         S_REQ:   if (mem.mem_ack && !mem.mem_valid) state_d = S_WAIT;
         S_WAIT:  ;
         S_PAUSE: begin
            if (!stall) begin
               if (pcnt_q == P_LAST) begin
                  pcnt_d = '0;
                  if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                     col_d   = '0;
                     row_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     col_d   = col_q + CW'(1);
                     if (col_q == COL_LAST) row_d = row_q + RW'(1);
                     state_d = S_REQ;
                  end
               end else begin
                  pcnt_d = pcnt_q + PW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (beat) begin
         if (k_q == K_LAST) begin
            k_d         = '0;
            win_valid_d = 1'b1;
            state_d     = S_PAUSE;
         end else begin
            k_d     = k_q + KW'(1);
            state_d = S_REQ;
         end
      end

      mem_req_d  = (state_d == S_REQ);
      mem_addr_d = (state_d == S_REQ) ? addr_of(row_d, k_d, col_d) : '0;
      busy_d     = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_PAUSE);
      done_d     = (state_d == S_DONE);
   end

   // State, counters and registered outputs; reset abandons any outstanding read.
   always_ff @(posedge nclk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         k_q         <= '0;
         pcnt_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         win_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         k_q         <= k_d;
         pcnt_q      <= pcnt_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         win_valid_q <= win_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign win_valid    = win_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_sobel_fetch_ctrl.sv
// Bench for sobel_fetch_ctrl: two instances (BASEADDR 0 and 12, 4-bit addresses)
// share stimulus; a beat/window-level model predicts every output each cycle.
module tb_sobel_fetch_ctrl;
   localparam int RWD = 4, NR = 4, NB = 3, NP = 1;
   localparam int NBEAT = RWD * (NR - NB + 1) * NB;   // 24 beats per frame
   localparam int NWIN  = RWD * (NR - NB + 1);        // 8 windows per frame

   logic nclk = 1'b0;
   logic rst, st_main, st_rnd, stl_main, stl_rnd, ack_r, valid_r;
   logic start, stall;
   logic pop0, win0, busy0, done0, pop1, win1, busy1, done1;
   assign start = st_main | st_rnd;
   assign stall = stl_main | stl_rnd;

   always #5 nclk = ~nclk;

   sobel_fetch_ctrl_if #(.ADDRW(4)) m0();
   sobel_fetch_ctrl_if #(.ADDRW(4)) m1();
   assign m0.mem_ack = ack_r;  assign m0.mem_valid = valid_r;
   assign m1.mem_ack = ack_r;  assign m1.mem_valid = valid_r;

   sobel_fetch_ctrl #(.BASEADDR(0), .ADDRW(4), .ROWWORDS(RWD), .ROWS(NR), .BEATS(NB), .PAUSE(NP))
      dut0 (.nclk(nclk), .reset(rst), .start(start), .stall(stall), .mem(m0),
            .pop_en(pop0), .win_valid(win0), .busy(busy0), .done(done0));
   sobel_fetch_ctrl #(.BASEADDR(12), .ADDRW(4), .ROWWORDS(RWD), .ROWS(NR), .BEATS(NB), .PAUSE(NP))
      dut1 (.nclk(nclk), .reset(rst), .start(start), .stall(stall), .mem(m1),
            .pop_en(pop1), .win_valid(win1), .busy(busy1), .done(done1));

   int checks = 0, errors = 0;
   int pop_cnt = 0, win_cnt = 0, done_cnt = 0;
   int seq0 [NBEAT];
   int seq1 [NBEAT];
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Memory responder: per-request ack and valid delays; optional noise on idle bus.
   int ack_dly = 0, val_dly = 0, acnt = 0, vcnt = 0, vd = 0;
   logic in_req = 1'b0, noise = 1'b0, rnd_on = 1'b0;
   initial begin
      ack_r = 0; valid_r = 0;
      forever begin
         @(posedge nclk); #1;
         ack_r = 0; valid_r = 0;
         if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) valid_r = 1;
         end else if (m0.mem_req) begin
            if (!in_req) begin
               in_req = 1;
               acnt = (ack_dly < 0) ? int'($urandom_range(3, 0)) : ack_dly;
            end
            if (acnt == 0) begin
               ack_r = 1; in_req = 0;
               vd = (val_dly < 0) ? int'($urandom_range(3, 0)) : val_dly;
               if (vd == 0) valid_r = 1; else vcnt = vd;
            end else acnt--;
         end else in_req = 0;
         if (noise && !m0.mem_req && vcnt == 0 && !valid_r && !ack_r) begin
            ack_r   = ($urandom_range(2, 0) == 0);
            valid_r = ($urandom_range(2, 0) == 0);
         end
      end
   end

   // Random stall, and spurious start while a frame is running.
   initial begin
      st_rnd = 0; stl_rnd = 0;
      forever begin
         @(posedge nclk); #1;
         st_rnd  = rnd_on && busy0 && ($urandom_range(7, 0) == 0);
         stl_rnd = rnd_on && ($urandom_range(3, 0) == 0);
      end
   end

   // Behavioural model: beat index into the frame's address list, whether a
   // request is pending or accepted, and how many unstalled pause cycles remain.
   logic m_act = 0, m_req = 0, m_out = 0, e_busy = 0, e_win = 0, e_done = 0;
   int   m_pause = 0, m_idx = 0;
   always @(negedge nclk) begin
      logic ep, nwin, ndone;
      if (chk_en) begin
         chk("busy0", busy0, e_busy);     chk("busy1", busy1, e_busy);
         chk("req0", m0.mem_req, m_req);  chk("req1", m1.mem_req, m_req);
         chk("win0", win0, e_win);        chk("win1", win1, e_win);
         chk("done0", done0, e_done);     chk("done1", done1, e_done);
         if (m_req) begin
            chk("addr0", m0.mem_addr, seq0[m_idx]);
            chk("addr1", m1.mem_addr, seq1[m_idx]);
         end
         ep = (m_req && ack_r && valid_r) || (m_out && valid_r);
         chk("pop0", pop0, ep);  chk("pop1", pop1, ep);
         if (pop0) pop_cnt++;
         if (win0) win_cnt++;
         if (done0) done_cnt++;
         nwin = 0; ndone = 0;
         if (rst) begin
            m_act = 0; m_req = 0; m_out = 0; m_pause = 0; m_idx = 0;
         end else if (!m_act) begin
            if (start && !e_done) begin m_act = 1; m_req = 1; end
         end else if (ep) begin
            m_req = 0; m_out = 0; m_idx++;
            if (m_idx % NB == 0) begin nwin = 1; m_pause = NP + 1; end
            else m_req = 1;
         end else if (m_req && ack_r) begin
            m_req = 0; m_out = 1;
         end else if (m_pause > 0 && !stall) begin
            m_pause--;
            if (m_pause == 0) begin
               if (m_idx == NBEAT) begin m_act = 0; m_idx = 0; ndone = 1; end
               else m_req = 1;
            end
         end
         e_win = nwin; e_done = ndone; e_busy = m_act;
      end
   end

   task automatic do_start(input string nm);
      st_main = 1; @(posedge nclk); #1; st_main = 0;
      chk({nm, "_busy_t1"}, busy0, 1);
      chk({nm, "_req_t1"}, m0.mem_req, 1);
      chk({nm, "_addr0_first"}, m0.mem_addr, 0);
      chk({nm, "_addr1_first"}, m1.mem_addr, 12);
   endtask

   task automatic finish_frame(input string nm, input int p0, input int w0, input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin @(posedge nclk); #1; n++; end
      chk({nm, "_done_seen"}, int'(done_cnt != d0), 1);
      repeat (3) begin @(posedge nclk); #1; end
      chk({nm, "_pops"}, pop_cnt - p0, NBEAT);
      chk({nm, "_wins"}, win_cnt - w0, NWIN);
      chk({nm, "_dones"}, done_cnt - d0, 1);
      chk({nm, "_busy_end"}, busy0, 0);
   endtask

   task automatic run_frame(input string nm);
      int p0, w0, d0;
      p0 = pop_cnt; w0 = win_cnt; d0 = done_cnt;
      do_start(nm);
      finish_frame(nm, p0, w0, d0);
   endtask

   initial begin
      int n, p0, w0, d0;
      rst = 1; st_main = 0; stl_main = 0;
      n = 0;
      for (int r = 0; r <= NR - NB; r++)
         for (int c = 0; c < RWD; c++)
            for (int k = 0; k < NB; k++) begin
               seq0[n] = ((r + k) * RWD + c) % 16;
               seq1[n] = (12 + (r + k) * RWD + c) % 16;
               n++;
            end
      chk("model_n", n, 24);
      chk("model_s0_0", seq0[0], 0);  chk("model_s0_1", seq0[1], 4);
      chk("model_s0_2", seq0[2], 8);  chk("model_s0_3", seq0[3], 1);
      chk("model_s0_23", seq0[23], 15);
      chk("model_s1_0", seq1[0], 12); chk("model_s1_1", seq1[1], 0);
      chk("model_s1_2", seq1[2], 4);

      @(posedge nclk); #1; chk_en = 1;
      @(posedge nclk); #1;
      chk("rst_busy", busy0, 0); chk("rst_req", m0.mem_req, 0);
      chk("rst_addr", m0.mem_addr, 0); chk("rst_win", win0, 0);
      chk("rst_done", done0, 0); chk("rst_pop", pop0, 0);
      rst = 0;
      @(posedge nclk); #1;

      // Same-cycle ack+valid.
      run_frame("t1");

      // Ack after 3 waits, valid 2 cycles after ack.
      ack_dly = 3; val_dly = 2;
      p0 = pop_cnt; w0 = win_cnt; d0 = done_cnt;
      do_start("t2");
      n = 0;
      while (m0.mem_req && n < 10) begin n++; @(posedge nclk); #1; end
      chk("t2_req_hold", n, 4);
      finish_frame("t2", p0, w0, d0);
      ack_dly = 0; val_dly = 0;

      // Stall held through the end of the first pause.
      p0 = pop_cnt; w0 = win_cnt; d0 = done_cnt;
      do_start("t3");
      n = 0;
      while (!win0 && n < 50) begin @(posedge nclk); #1; n++; end
      chk("t3_win_seen", win0, 1);
      @(posedge nclk); #1; stl_main = 1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_no_req_stall", m0.mem_req, 0);
         @(posedge nclk); #1;
      end
      stl_main = 0;
      @(posedge nclk); #1;
      chk("t3_req_after", m0.mem_req, 1);
      chk("t3_addr_after", m0.mem_addr, 1);
      finish_frame("t3", p0, w0, d0);

      // Reset while waiting for the read of address 5; its late data is ignored.
      val_dly = 4;
      do_start("t4");
      n = 0;
      while (!(m0.mem_req && m0.mem_addr == 5) && n < 100) begin @(posedge nclk); #1; n++; end
      chk("t4_addr5_seen", int'(m0.mem_req && m0.mem_addr == 5), 1);
      @(posedge nclk); #1; rst = 1;
      @(posedge nclk); #1; rst = 0;
      p0 = pop_cnt;
      chk("t4_busy0", busy0, 0); chk("t4_req0", m0.mem_req, 0);
      chk("t4_addr0", m0.mem_addr, 0); chk("t4_win0", win0, 0);
      chk("t4_done0", done0, 0);
      repeat (6) begin @(posedge nclk); #1; end
      chk("t4_late_pop", pop_cnt - p0, 0);
      val_dly = 0;
      run_frame("t4r");

      // Random delays, stalls, spurious start/ack/valid.
      ack_dly = -1; val_dly = -1; noise = 1; rnd_on = 1;
      for (int f = 0; f < 3; f++) run_frame("rnd");
      noise = 0; rnd_on = 0;
      repeat (4) @(posedge nclk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sobel_fetch_ctrl.md
# sobel_fetch_ctrl

Sequencing controller that feeds the Sobel row-buffer block. It walks the image in memory column by column. For each output window it issues BEATS single-word reads, one per vertically adjacent row, over a req/ack/valid memory handshake. Each returned word produces a pop strobe to the buffer block, followed by a window-complete pulse and a programmable pause. It sits between the frame-start logic, the pixel memory read port and the row-buffer block.

## Interface
- BASEADDR, 0: word address of pixel row 0, column 0.
- ADDRW, 21: memory word-address width.
- ROWWORDS, 256: 64-bit words per image row; power of two, ≥2.
- ROWS, 8192: image rows; ≥BEATS.
- BEATS, 3: reads (rows) per window; ≥1.
- PAUSE, 1: idle cycles after each window; ≥0.

- nclk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame start; sampled only in IDLE.
- stall  in  1  downstream backpressure; holds in PAUSE.
- mem_req  out  1  read request, held until accepted.
- mem_addr  out  ADDRW  read word address, stable while mem_req=1.
- mem_ack  in  1  request accepted this cycle (valid only with mem_req=1).
- mem_valid  in  1  read data present this cycle.
- pop_en  out  1  strobe to buffer block: capture current read data.
- win_valid  out  1  one-cycle pulse: BEATS words of a window delivered.
- busy  out  1  high from the first cycle after start until done.
- done  out  1  one-cycle pulse at frame end.

## Operation
- Counters:
  - col: 0..ROWWORDS-1.
  - row: 0..ROWS-BEATS.
  - k: 0..BEATS-1.
  - pcnt: 0..PAUSE.
- Address: mem_addr = (BASEADDR + (row+k)*ROWWORDS + col) mod 2^ADDRW. Truncation is the only overflow rule.
- FSM states: IDLE, REQ, WAIT, PAUSE, DONE.
- IDLE: all counters are 0. start=1 → REQ.
- REQ: mem_req=1 with the current address.
  - mem_ack=0 → stay.
  - mem_ack=1, mem_valid=0 → WAIT.
  - mem_ack=1 and mem_valid=1 in the same cycle → treat as a completed beat (see WAIT).
- WAIT: at most one read is outstanding.
  - mem_valid=1 → pop_en=1 in the same cycle (combinational from state & mem_valid).
  - Beat complete with k<BEATS-1 → k++, go to REQ.
  - Beat complete with k=BEATS-1 → k=0, win_valid=1 next cycle, go to PAUSE.
- PAUSE: counts PAUSE cycles; pcnt is frozen while stall=1.
  - Exit requires pcnt=PAUSE and stall=0. With PAUSE=0, the state lasts one cycle, or longer while stall=1.
  - On exit, col++. If col wraps to 0, row++.
  - On exit, if the finished window was at col=ROWWORDS-1 and row=ROWS-BEATS → DONE; otherwise → REQ.
- DONE: done=1 for one cycle, busy=0 in that cycle, then → IDLE.
- Window count per frame: ROWWORDS*(ROWS-BEATS+1). pop_en count: BEATS times the window count.
- Ignored inputs:
  - mem_valid outside REQ/WAIT produces no pop_en and no state change.
  - mem_ack with mem_req=0 is ignored.
  - start outside IDLE is ignored.
- Reset, at any time including mid-read: next state IDLE and all counters 0. All outputs are 0: mem_req, mem_addr, pop_en, win_valid, busy, done. An outstanding read is abandoned and its late mem_valid is ignored.

## Timing
- start at cycle t (in IDLE) → busy=1 and mem_req=1 at t+1.
- Per-beat cost:
  - ack+valid in the same cycle: 1 cycle per beat.
  - ack then valid next cycle: 2 cycles.
  - Otherwise: 1 + ack wait + valid wait.
- The next mem_req rises the cycle after the pop of the previous beat. There are no bubbles besides REQ.
- Final pop of a window at cycle t → win_valid at t+1, and PAUSE occupies t+1..t+1+PAUSE with no stall. The next mem_req is at t+2+PAUSE.
- mem_addr and mem_req are registered outputs. pop_en is combinational. win_valid, busy and done are registered.

## Test plan
- Small config (ROWWORDS=4, ROWS=4, BEATS=3, PAUSE=1, ADDRW=4, BASEADDR=0), memory acks and returns valid in the same cycle → address sequence 0,4,8, 1,5,9, … ,3,7,11, 4,8,12, … ,7,11,15. Expect 24 pop_en, 8 win_valid, exactly one done, then busy=0.
- Same config with mem_ack delayed 3 cycles and mem_valid 2 cycles after ack → mem_req and mem_addr held stable for 4 cycles and no pop_en before mem_valid. Total pops still 24.
- stall held high for 5 cycles during the first PAUSE → no mem_req during the stall. Address 1 is requested the cycle after stall falls (PAUSE already elapsed).
- reset pulsed while in WAIT for address 5 → all outputs 0 on the next cycle. A mem_valid 2 cycles later gives no pop_en. A new start restarts at address 0.
- start pulsed again mid-frame and mem_valid asserted while IDLE → no effect. Window count stays 8, with no extra pop_en.
- BASEADDR=12, ADDRW=4 → first window addresses 12, 0, 4 (mod-16 wrap). Every following window is likewise its unwrapped address mod 16.
